// File: rtl/keypad_entry_ctrl.sv
// Keypad entry controller: gates and debounces the keypad priority encoder, builds a
// 4-digit MM:SS entry, and hands it to the countdown timer with a one-cycle load pulse.
module keypad_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  bcd_in,
    input  logic        data_val,
    input  logic        clear,
    input  logic        start,
    input  logic        timer_busy,
    output logic        enablen,
    output logic [15:0] digits,
    output logic [2:0]  digit_cnt,
    output logic        key_strobe,
    output logic        load,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_CAPTURE,
        S_RELEASE,
        S_RUN
    } state_t;

    localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_code;
    logic [3:0]       w_code_nxt;
    logic [15:0]      r_digits;
    logic [15:0]      w_digits_nxt;
    logic [2:0]       r_dcnt;
    logic [2:0]       w_dcnt_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_load;
    logic             w_load_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_busy_q;
    logic             w_accept;

    assign w_cnt_inc = r_cnt + CNT_ONE;

    // A key is taken unless the entry is full or it would be a leading zero.
    assign w_accept = (r_dcnt != 3'd4) && !((r_dcnt == 3'd0) && (r_code == 4'd0));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_code   <= 4'd0;
            r_digits <= 16'd0;
            r_dcnt   <= 3'd0;
            r_cnt    <= '0;
            r_load   <= 1'b0;
            r_err    <= 1'b0;
            r_busy_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_code   <= w_code_nxt;
            r_digits <= w_digits_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_cnt    <= w_cnt_nxt;
            r_load   <= w_load_nxt;
            r_err    <= w_err_nxt;
            r_busy_q <= timer_busy;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_digits_nxt = r_digits;
        w_dcnt_nxt   = r_dcnt;
        w_cnt_nxt    = r_cnt;
        w_load_nxt   = 1'b0;
        w_err_nxt    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_digits_nxt = 16'd0;
                    w_dcnt_nxt   = 3'd0;
                end else if (start) begin
                    if (r_dcnt != 3'd0) begin
                        if (r_digits[7:4] > 4'd5) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_load_nxt  = 1'b1;
                            w_state_nxt = S_RUN;
                        end
                    end
                end else if (data_val) begin
                    w_code_nxt  = bcd_in;
                    w_cnt_nxt   = CNT_ONE;
                    w_state_nxt = S_DEBOUNCE;
                end
            end

            S_DEBOUNCE: begin
                if (clear) begin
                    w_digits_nxt = 16'd0;
                    w_dcnt_nxt   = 3'd0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_RELEASE;
                end else if (!data_val || (bcd_in != r_code)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == DB_LIM) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            S_CAPTURE: begin
                if (clear) begin
                    w_digits_nxt = 16'd0;
                    w_dcnt_nxt   = 3'd0;
                end else if (w_accept) begin
                    w_digits_nxt = {r_digits[11:0], r_code};
                    w_dcnt_nxt   = r_dcnt + 3'd1;
                end
                w_cnt_nxt   = '0;
                w_state_nxt = S_RELEASE;
            end

            // Wait for a clean release so a held key never repeats.
            S_RELEASE: begin
                if (clear) begin
                    w_digits_nxt = 16'd0;
                    w_dcnt_nxt   = 3'd0;
                    w_cnt_nxt    = '0;
                end else if (data_val) begin
                    w_cnt_nxt = '0;
                end else if (w_cnt_inc == DB_LIM) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end

            // Exit on the falling edge of timer_busy, seen through its registered copy.
            S_RUN: begin
                if (r_busy_q && !timer_busy) begin
                    w_digits_nxt = 16'd0;
                    w_dcnt_nxt   = 3'd0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign enablen    = (r_state == S_RUN);
    assign key_strobe = (r_state == S_CAPTURE) && w_accept;
    assign digits     = r_digits;
    assign digit_cnt  = r_dcnt;
    assign load       = r_load;
    assign err        = r_err;

endmodule
